// File: rtl/rv32c_compressor.sv
`default_nettype none
// ============================================================================
//  Module   : rv32c_compressor
//  Purpose  : Streaming RV32I -> RVC re-encoder. Each accepted instruction is
//             turned into a 16-bit RVC halfword when an exact encoding exists
//             (immediates limited to 0..31 so the in-house expander
//             round-trips). Otherwise it is passed through as 32 bits.
//             Results are packed little-endian into 32-bit output words.
//  Ports    : clk, rst_n            clock / async active-low reset
//             in_valid/in_ready     input handshake, in_inst instruction
//             flush / flush_busy    request to emit a pending halfword
//             out_valid/out_ready   output handshake, out_word packed word
//             cmp_count             saturating count of 16-bit results
//  Revision : 1.0  initial release
// ============================================================================
module rv32c_compressor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic        flush,
  output logic        flush_busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [15:0] cmp_count
);

  // Instruction fields
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic       rd_c, rs1_c, rs2_c, imm_lo, alu_ok;

  assign opc    = in_inst[6:0];
  assign rd     = in_inst[11:7];
  assign f3     = in_inst[14:12];
  assign rs1    = in_inst[19:15];
  assign rs2    = in_inst[24:20];   // also I-type imm[4:0] / shamt
  assign f7     = in_inst[31:25];
  assign rd_c   = (rd[4:3]  == 2'b01); // x8..x15
  assign rs1_c  = (rs1[4:3] == 2'b01);
  assign rs2_c  = (rs2[4:3] == 2'b01);
  assign imm_lo = (f7 == 7'd0);        // I-type immediate within 0..31
  assign alu_ok = rd_c && (rs1 == rd) && rs2_c;

  logic        c_ok;
  logic [15:0] c_half;

  always_comb begin
    c_ok   = 1'b0;
    c_half = 16'h0000;
    if (in_inst[1:0] != 2'b11) begin
      // Already an RVC halfword; the upper half is ignored.
      c_ok   = 1'b1;
      c_half = in_inst[15:0];
    end else if (in_inst == 32'h0010_0073) begin
      c_ok   = 1'b1;
      c_half = 16'h9002;
    end else begin
      case (opc)
        7'b0010011: begin
          case (f3)
            3'b000: begin
              if (rd == 5'd0 && rs1 == 5'd0 && in_inst[31:20] == 12'd0) begin
                c_ok = 1'b1; c_half = 16'h0001;
              end else if (rd != 5'd0 && rs1 == 5'd0 && imm_lo) begin
                c_ok = 1'b1; c_half = {3'b010, 1'b0, rd, rs2, 2'b01};
              end else if (rd != 5'd0 && rs1 == rd && imm_lo && rs2 != 5'd0) begin
                c_ok = 1'b1; c_half = {3'b000, 1'b0, rd, rs2, 2'b01};
              end
            end
            3'b001: begin
              if (imm_lo && rd != 5'd0 && rs1 == rd && rs2 != 5'd0) begin
                c_ok = 1'b1; c_half = {3'b000, 1'b0, rd, rs2, 2'b10};
              end
            end
            3'b101: begin
              // f7[5] selects SRAI; it lands directly in funct2 bit 10.
              if ((f7 == 7'b0000000 || f7 == 7'b0100000) && rd_c && rs1 == rd
                  && rs2 != 5'd0) begin
                c_ok = 1'b1; c_half = {3'b100, 1'b0, 1'b0, f7[5], rd[2:0], rs2, 2'b01};
              end
            end
            3'b111: begin
              if (imm_lo && rd_c && rs1 == rd) begin
                c_ok = 1'b1; c_half = {3'b100, 1'b0, 2'b10, rd[2:0], rs2, 2'b01};
              end
            end
            default: ;
          endcase
        end
        7'b0110111: begin
          if (rd != 5'd0 && rd != 5'd2 && in_inst[31:17] == 15'd0
              && in_inst[16:12] != 5'd0) begin
            c_ok = 1'b1; c_half = {3'b011, 1'b0, rd, in_inst[16:12], 2'b01};
          end
        end
        7'b0110011: begin
          if (f7 == 7'b0100000) begin
            if (f3 == 3'b000 && alu_ok) begin
              c_ok = 1'b1; c_half = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b00, rs2[2:0], 2'b01};
            end
          end else if (f7 == 7'b0000000) begin
            case (f3)
              3'b000: begin
                if (rd != 5'd0 && rs2 != 5'd0) begin
                  if (rs1 == 5'd0) begin
                    c_ok = 1'b1; c_half = {3'b100, 1'b0, rd, rs2, 2'b10};
                  end else if (rs1 == rd) begin
                    c_ok = 1'b1; c_half = {3'b100, 1'b1, rd, rs2, 2'b10};
                  end
                end
              end
              3'b100: if (alu_ok) begin
                c_ok = 1'b1; c_half = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b01, rs2[2:0], 2'b01};
              end
              3'b110: if (alu_ok) begin
                c_ok = 1'b1; c_half = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b10, rs2[2:0], 2'b01};
              end
              3'b111: if (alu_ok) begin
                c_ok = 1'b1; c_half = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b11, rs2[2:0], 2'b01};
              end
              default: ;
            endcase
          end
        end
        7'b0000011: begin
          // offset[11:7]==0 and offset[1:0]==0 -> word offset 0..124
          if (f3 == 3'b010 && in_inst[31:27] == 5'd0 && in_inst[21:20] == 2'b00
              && rs1_c && rd_c) begin
            c_ok   = 1'b1;
            c_half = {3'b010, in_inst[25:23], rs1[2:0], in_inst[22], in_inst[26],
                      rd[2:0], 2'b00};
          end
        end
        7'b0100011: begin
          // S-type offset = {inst[31:25], inst[11:7]}
          if (f3 == 3'b010 && in_inst[31:27] == 5'd0 && in_inst[8:7] == 2'b00
              && rs1_c && rs2_c) begin
            c_ok   = 1'b1;
            c_half = {3'b110, in_inst[25], in_inst[11:10], rs1[2:0], in_inst[9],
                      in_inst[26], rs2[2:0], 2'b00};
          end
        end
        default: ;
      endcase
    end
  end

  // Packing state and output slot
  logic [15:0] hold_q, hold_d;
  logic        hold_v_q, hold_v_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_word_q, out_word_d;
  logic        pend_q, pend_d;
  logic [15:0] cnt_q, cnt_d;
  logic        accept;

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_word   = out_word_q;
  assign flush_busy = pend_q;
  assign cmp_count  = cnt_q;

  always_comb begin
    hold_d      = hold_q;
    hold_v_d    = hold_v_q;
    out_valid_d = out_valid_q && !out_ready;
    out_word_d  = out_word_q;
    pend_d      = pend_q || flush;   // a flush while busy is absorbed
    cnt_d       = cnt_q;

    if (accept) begin
      if (c_ok) begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (hold_v_q) begin
          out_word_d  = {c_half, hold_q};
          out_valid_d = 1'b1;
          hold_v_d    = 1'b0;
        end else begin
          hold_d   = c_half;
          hold_v_d = 1'b1;
        end
      end else if (hold_v_q) begin
        // 32-bit instruction straddles: low half completes this word.
        out_word_d  = {in_inst[15:0], hold_q};
        out_valid_d = 1'b1;
        hold_d      = in_inst[31:16];
      end else begin
        out_word_d  = in_inst;
        out_valid_d = 1'b1;
      end
    end

    // Pending flush: nothing held -> done at once; otherwise wait for a
    // cycle with no input accepted and a free output slot, pad with C.NOP.
    if (pend_q) begin
      if (!hold_v_q) begin
        pend_d = 1'b0;
      end else if (!accept && in_ready) begin
        out_word_d  = {16'h0001, hold_q};
        out_valid_d = 1'b1;
        hold_v_d    = 1'b0;
        pend_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= 16'h0000;
      hold_v_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_word_q  <= 32'h0000_0000;
      pend_q      <= 1'b0;
      cnt_q       <= 16'h0000;
    end else begin
      hold_q      <= hold_d;
      hold_v_q    <= hold_v_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32c_compressor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32c_compressor
//  Purpose  : Self-checking bench for rv32c_compressor: directed scenarios
//             plus a randomized stream checked against a halfword-queue
//             packing model and a field-level compression reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rv32c_compressor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, flush_busy, out_valid, out_ready;
  logic [31:0] in_inst, out_word;
  logic [15:0] cmp_count;

  rv32c_compressor dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .flush(flush), .flush_busy(flush_busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .cmp_count(cmp_count)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] hq[$];       // halfwords not yet forming a full word
  logic [31:0] expq[$];     // words expected on the output, in order
  logic        mpend;
  int          exp_cmp;
  logic        stall_prev;
  logic [31:0] stall_word;
  logic [31:0] last_word;
  logic        acc_last;
  logic        rand_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit isc(input logic [4:0] r);
    return (r >= 5'd8) && (r <= 5'd15);
  endfunction

  // Returns {compressible, halfword}, derived from instruction semantics.
  function automatic logic [16:0] ref_compress(input logic [31:0] i);
    logic [6:0] op, f7, off;
    logic [4:0] rd, rs1, rs2, v5;
    logic [2:0] f3;
    int simm, sfimm, u20;
    op = i[6:0]; rd = i[11:7]; f3 = i[14:12]; rs1 = i[19:15]; rs2 = i[24:20]; f7 = i[31:25];
    simm  = int'($signed(i[31:20]));
    sfimm = int'($signed({i[31:25], i[11:7]}));
    u20   = int'(i[31:12]);
    if (i[1:0] != 2'b11) return {1'b1, i[15:0]};
    if (i == 32'h00100073) return {1'b1, 16'h9002};
    if (op == 7'h13 && f3 == 3'd0) begin
      if (rd == 0 && rs1 == 0 && simm == 0) return {1'b1, 16'h0001};
      if (rd != 0 && rs1 == 0 && simm >= 0 && simm <= 31) begin
        v5 = 5'(simm); return {1'b1, 3'b010, 1'b0, rd, v5, 2'b01};
      end
      if (rd != 0 && rs1 == rd && simm >= 1 && simm <= 31) begin
        v5 = 5'(simm); return {1'b1, 3'b000, 1'b0, rd, v5, 2'b01};
      end
    end
    if (op == 7'h13 && f3 == 3'd1 && f7 == 0 && rd != 0 && rs1 == rd && rs2 != 0)
      return {1'b1, 3'b000, 1'b0, rd, rs2, 2'b10};
    if (op == 7'h13 && f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20) && isc(rd) && rs1 == rd && rs2 != 0)
      return {1'b1, 3'b100, 1'b0, (f7 == 7'h20) ? 2'b01 : 2'b00, rd[2:0], rs2, 2'b01};
    if (op == 7'h13 && f3 == 3'd7 && isc(rd) && rs1 == rd && simm >= 0 && simm <= 31) begin
      v5 = 5'(simm); return {1'b1, 3'b100, 1'b0, 2'b10, rd[2:0], v5, 2'b01};
    end
    if (op == 7'h37 && rd != 0 && rd != 2 && u20 >= 1 && u20 <= 31) begin
      v5 = 5'(u20); return {1'b1, 3'b011, 1'b0, rd, v5, 2'b01};
    end
    if (op == 7'h33 && isc(rd) && rs1 == rd && isc(rs2)) begin
      if (f7 == 7'h20 && f3 == 3'd0) return {1'b1, 6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
      if (f7 == 7'h00 && f3 == 3'd4) return {1'b1, 6'b100011, rd[2:0], 2'b01, rs2[2:0], 2'b01};
      if (f7 == 7'h00 && f3 == 3'd6) return {1'b1, 6'b100011, rd[2:0], 2'b10, rs2[2:0], 2'b01};
      if (f7 == 7'h00 && f3 == 3'd7) return {1'b1, 6'b100011, rd[2:0], 2'b11, rs2[2:0], 2'b01};
    end
    if (op == 7'h33 && f7 == 0 && f3 == 0 && rd != 0 && rs2 != 0) begin
      if (rs1 == 0)  return {1'b1, 3'b100, 1'b0, rd, rs2, 2'b10};
      if (rs1 == rd) return {1'b1, 3'b100, 1'b1, rd, rs2, 2'b10};
    end
    if (op == 7'h03 && f3 == 3'd2 && isc(rd) && isc(rs1) && simm >= 0 && simm <= 124 && simm % 4 == 0) begin
      off = 7'(simm);
      return {1'b1, 3'b010, off[5:3], rs1[2:0], off[2], off[6], rd[2:0], 2'b00};
    end
    if (op == 7'h23 && f3 == 3'd2 && isc(rs2) && isc(rs1) && sfimm >= 0 && sfimm <= 124 && sfimm % 4 == 0) begin
      off = 7'(sfimm);
      return {1'b1, 3'b110, off[5:3], rs1[2:0], off[2], off[6], rs2[2:0], 2'b00};
    end
    return 17'h0;
  endfunction

  function automatic logic [4:0] rreg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(8, 15));
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] r;
    rd  = rreg();
    rs1 = ($urandom_range(0, 1) == 1) ? rd : rreg();
    rs2 = rreg();
    case ($urandom_range(0, 3))
      0:       imm = 12'($urandom_range(0, 31));
      1:       imm = 12'($urandom_range(32, 130));
      2:       imm = 12'($urandom_range(0, 4095));
      default: imm = 12'($urandom_range(0, 31) * 4);
    endcase
    f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    r  = $urandom();
    case ($urandom_range(0, 13))
      0:  return {imm, rs1, 3'b000, rd, 7'h13};
      1:  return {imm, 5'd0, 3'b000, rd, 7'h13};
      2:  return {7'h00, imm[4:0], rs1, 3'b001, rd, 7'h13};
      3:  return {f7, imm[4:0], rs1, 3'b101, rd, 7'h13};
      4:  return {imm, rs1, 3'b111, rd, 7'h13};
      5: begin
        f3 = 3'($urandom_range(4, 7));
        if (f3 == 3'd5) f3 = 3'd0;
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
      6:  return {7'h00, rs2, ($urandom_range(0, 1) == 1) ? 5'd0 : rs1, 3'b000, rd, 7'h33};
      7:  return {8'h00, imm, rd, 7'h37};
      8:  return {imm, rs1, 3'b010, rd, 7'h03};
      9:  return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
      10: return 32'h00100073;
      11: begin r[1:0] = 2'($urandom_range(0, 2)); return r; end
      12: begin r[6:0] = 7'h63; return r; end
      default: begin r[1:0] = 2'b11; return r; end
    endcase
  endfunction

  task automatic reset_model();
    hq.delete(); expq.delete();
    mpend = 1'b0; exp_cmp = 0; stall_prev = 1'b0; stall_word = 32'h0;
  endtask

  // One clock: sample/check at negedge, advance model, return at posedge+1.
  task automatic tick();
    logic        acc, slot, was_empty, clr;
    logic [16:0] r;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    slot = !out_valid || out_ready;
    chk("in_ready", {31'd0, in_ready}, {31'd0, slot});
    chk("flush_busy", {31'd0, flush_busy}, {31'd0, mpend});
    chk("cmp_count", {16'd0, cmp_count}, exp_cmp);
    if (stall_prev) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_word", out_word, stall_word);
    end
    if (out_valid && out_ready) begin
      chk("word_expected", (expq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (expq.size() > 0) chk("out_word", out_word, expq.pop_front());
      last_word = out_word;
    end
    stall_prev = out_valid && !out_ready;
    stall_word = out_word;
    acc        = in_valid && slot;
    acc_last   = acc;
    was_empty  = (hq.size() == 0);
    clr        = mpend && (was_empty || (!acc && slot));
    if (mpend && !was_empty && !acc && slot) hq.push_back(16'h0001);
    if (acc) begin
      r = ref_compress(in_inst);
      if (r[16]) begin
        hq.push_back(r[15:0]);
        if (exp_cmp < 65535) exp_cmp++;
      end else begin
        hq.push_back(in_inst[15:0]);
        hq.push_back(in_inst[31:16]);
      end
    end
    while (hq.size() >= 2) begin
      expq.push_back({hq[1], hq[0]});
      void'(hq.pop_front());
      void'(hq.pop_front());
    end
    mpend = clr ? 1'b0 : (mpend || flush);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send(input logic [31:0] inst);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    do begin
      tick();
      n++;
    end while (!acc_last && n < 200);
    chk("accepted", {31'd0, acc_last}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    int n;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n = 0;
    while (flush_busy && n < 50) begin
      tick();
      n++;
    end
    chk("flush_done", {31'd0, flush_busy}, 32'd0);
    idle(2);
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_inst = 32'h0; flush = 1'b0;
    out_ready = 1'b1; rand_ready = 1'b0; last_word = 32'h0; acc_last = 1'b0;
    reset_model();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_flush_busy", {31'd0, flush_busy}, 32'd0);
    chk("rst_cmp_count", {16'd0, cmp_count}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // addi x8,x8,5 + add x9,x9,x10 -> one packed word
    send(32'h00540413);
    send(32'h00A484B3);
    idle(2);
    chk("t1_word", last_word, 32'h94AA0415);
    chk("t1_cmp", {16'd0, cmp_count}, 32'd2);

    // compressed then straddling lui, then flush pads with C.NOP
    send(32'h00540413);
    send(32'h123452B7);
    idle(1);
    chk("t2_word", last_word, 32'h52B70415);
    do_flush();
    chk("t2_flush_word", last_word, 32'h00011234);

    // lw compresses; addi with negative immediate passes through
    send(32'h00852483);
    do_flush();
    chk("t3_flush_word", last_word, 32'h00014504);
    send(32'hFFF40413);
    idle(1);
    chk("t3_passthru", last_word, 32'hFFF40413);

    // reset while a halfword is held and an output word is stalled
    out_ready = 1'b0;
    send(32'h00540413);
    send(32'h123452B7);
    idle(2);
    chk("t5_stalled_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_word", out_word, 32'd0);
    chk("t5_rst_busy", {31'd0, flush_busy}, 32'd0);
    chk("t5_rst_cmp", {16'd0, cmp_count}, 32'd0);
    reset_model();
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(32'h123452B7);
    idle(1);
    chk("t5_unshifted", last_word, 32'h123452B7);

    // pre-compressed halfword
    send(32'h00009002);
    do_flush();
    chk("t6_flush_word", last_word, 32'h00019002);
    chk("t6_cmp", {16'd0, cmp_count}, 32'd1);

    // randomized mixed stream with consumer back-pressure
    rand_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      send(rand_inst());
      if ($urandom_range(0, 3) == 0) idle(1);
      if ($urandom_range(0, 7) == 0) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    idle(2);
    do_flush();
    idle(2);
    chk("drained", expq.size() + hq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
